// File: rtl/sd_phy_delay_tuner.sv
// sd_phy_delay_tuner
// Calibrates the PHY IODELAY tap. It resets the delay line, then sweeps
// every tap from 0 to MAX_TAP and asks the upper-layer tester for a verdict
// at each one. While sweeping it tracks the longest contiguous passing
// window. Afterwards it rewinds the delay line and steps it forward to the
// window centre.
module sd_phy_delay_tuner #(
    parameter int TAP_BITS       = 8,
    parameter int MAX_TAP        = 255,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_locked,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_fail,
    output logic [TAP_BITS-1:0] o_tap,
    output logic [TAP_BITS:0]   o_best_len,
    output logic                o_cfg_rst,
    output logic                o_cfg_en,
    output logic                o_cfg_inc,
    output logic                o_test_req,
    input  logic                i_test_done,
    input  logic                i_test_pass
);

    localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TAP_BITS-1:0]  LAST_TAP     = TAP_BITS'(MAX_TAP);

    // ABORT issues the cleanup delay reset after lock loss, before DONE
    typedef enum logic [3:0] {
        IDLE, DLY_RST, SETTLE, TEST, WAIT, STEP, EVAL,
        RW_RST, RW_SETTLE, RW_STEP, DONE, ABORT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [TAP_BITS-1:0]   cur_tap;
    logic [TAP_BITS-1:0]   run_start;
    logic [TAP_BITS-1:0]   best_start;
    logic [TAP_BITS:0]     run_len;
    logic [TAP_BITS:0]     run_len_inc;
    logic [TAP_BITS:0]     best_len;
    logic [TAP_BITS-1:0]   target;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [TIMEOUT_W-1:0]  timeout_cnt;
    logic                  pass_q;
    logic                  start_ok;
    logic                  busy_state;
    logic                  lock_lost;
    logic                  settle_last;
    logic                  timeout_last;
    logic                  finish_ok;
    logic                  finish_abort;

    assign start_ok     = i_start & i_locked;
    assign busy_state   = (state != IDLE) && (state != DONE);
    assign lock_lost    = busy_state && !i_locked && (state != ABORT);
    assign settle_last  = (settle_cnt == '0);
    assign timeout_last = (timeout_cnt == TIMEOUT_LAST);
    assign run_len_inc  = run_len + 1'b1;
    assign o_busy       = busy_state;
    assign o_cfg_inc    = o_cfg_en;

    // The window centre is rounded down. With no passing tap it falls back to tap 0.
    assign target = (best_len == '0) ? '0
                  : TAP_BITS'({1'b0, best_start} + ((best_len - 1'b1) >> 1));

    // Lock loss during a reset pulse finishes directly; this keeps the pulse one cycle wide.
    assign finish_abort = (state == ABORT)
                       || (lock_lost && (state == DLY_RST || state == RW_RST));
    assign finish_ok    = (state == RW_SETTLE) && (state_next == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and the one-cycle PHY and tester strobes
    always_comb begin
        state_next = state;
        o_cfg_rst  = 1'b0;
        o_cfg_en   = 1'b0;
        o_test_req = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = DLY_RST;
            end
            DONE: begin
                state_next = start_ok ? DLY_RST : IDLE;
            end
            DLY_RST: begin
                o_cfg_rst  = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_last) state_next = TEST;
            end
            TEST: begin
                o_test_req = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (i_test_done || timeout_last) state_next = EVAL;
            end
            EVAL: begin
                state_next = (cur_tap == LAST_TAP) ? RW_RST : STEP;
            end
            STEP: begin
                o_cfg_en   = 1'b1;
                state_next = SETTLE;
            end
            RW_RST: begin
                o_cfg_rst  = 1'b1;
                state_next = RW_SETTLE;
            end
            RW_SETTLE: begin
                if (settle_last) state_next = (cur_tap == target) ? DONE : RW_STEP;
            end
            RW_STEP: begin
                o_cfg_en   = 1'b1;
                state_next = RW_SETTLE;
            end
            ABORT: begin
                o_cfg_rst  = 1'b1;
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (lock_lost) begin
            state_next = (state == DLY_RST || state == RW_RST) ? DONE : ABORT;
        end
    end

    // Tap position, window trackers, settle and timeout counters, and results
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_tap     <= '0;
            run_start   <= '0;
            run_len     <= '0;
            best_start  <= '0;
            best_len    <= '0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            pass_q      <= 1'b0;
            o_done      <= 1'b0;
            o_fail      <= 1'b0;
            o_tap       <= '0;
            o_best_len  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        o_done     <= 1'b0;
                        o_fail     <= 1'b0;
                        cur_tap    <= '0;
                        run_start  <= '0;
                        run_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                    end
                end
                DLY_RST: begin
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE, RW_SETTLE: begin
                    if (!settle_last) settle_cnt <= settle_cnt - 1'b1;
                end
                TEST: begin
                    timeout_cnt <= '0;
                end
                WAIT: begin
                    if (i_test_done) begin
                        pass_q <= i_test_pass;
                    end else if (timeout_last) begin
                        pass_q <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (pass_q) begin
                        if (run_len == '0) run_start <= cur_tap;
                        run_len <= run_len_inc;
                        if (run_len_inc > best_len) begin
                            best_len   <= run_len_inc;
                            best_start <= (run_len == '0) ? cur_tap : run_start;
                        end
                    end else begin
                        run_len <= '0;
                    end
                end
                STEP, RW_STEP: begin
                    cur_tap    <= cur_tap + 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end
                RW_RST: begin
                    cur_tap    <= '0;
                    settle_cnt <= SETTLE_LOAD;
                end
                default: begin
                end
            endcase
            if (finish_abort) begin
                o_done     <= 1'b1;
                o_fail     <= 1'b1;
                o_tap      <= '0;
                o_best_len <= '0;
            end else if (finish_ok) begin
                o_done     <= 1'b1;
                o_fail     <= (best_len == '0);
                o_tap      <= target;
                o_best_len <= best_len;
            end
        end
    end

endmodule

// File: tb/tb_sd_phy_delay_tuner.sv
// Testbench for sd_phy_delay_tuner. A randomized tester answers tap
// requests from a per-tap pass table. A brute-force window search predicts
// the calibration result, and a pulse monitor timestamps every PHY strobe.
module tb_sd_phy_delay_tuner;

    localparam int TAP_BITS = 8;
    localparam int MAX_TAP  = 255;
    localparam int NTAPS    = MAX_TAP + 1;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 16;

    logic                clk;
    logic                rst;
    logic                i_locked;
    logic                i_start;
    logic                o_busy;
    logic                o_done;
    logic                o_fail;
    logic [TAP_BITS-1:0] o_tap;
    logic [TAP_BITS:0]   o_best_len;
    logic                o_cfg_rst;
    logic                o_cfg_en;
    logic                o_cfg_inc;
    logic                o_test_req;
    logic                i_test_done;
    logic                i_test_pass;

    logic [2*TAP_BITS+7:0] all_outs;
    assign all_outs = {o_busy, o_done, o_fail, o_tap, o_best_len,
                       o_cfg_rst, o_cfg_en, o_cfg_inc, o_test_req};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    bit stray_en = 0;
    bit stray_ok = 0;
    bit pattern [NTAPS];
    bit silent  [NTAPS];
    int rst_q[$];
    int en_q[$];
    int req_q[$];
    bit prev_en  = 0;
    bit prev_rst = 0;

    sd_phy_delay_tuner #(
        .TAP_BITS      (TAP_BITS),
        .MAX_TAP       (MAX_TAP),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_locked   (i_locked),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_fail     (o_fail),
        .o_tap      (o_tap),
        .o_best_len (o_best_len),
        .o_cfg_rst  (o_cfg_rst),
        .o_cfg_en   (o_cfg_en),
        .o_cfg_inc  (o_cfg_inc),
        .o_test_req (o_test_req),
        .i_test_done(i_test_done),
        .i_test_pass(i_test_pass)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Tester: it answers 1..3 cycles after each request unless the tap is silent.
    // It may also inject stray strobes that are outside any WAIT.
    initial begin
        int tap;
        i_test_done = 0;
        i_test_pass = 0;
        forever begin
            @(negedge clk);
            i_test_done = 0;
            if (o_test_req) begin
                tap = req_cnt;
                req_cnt++;
                if (tap < NTAPS && !silent[tap]) begin
                    stray_ok = 1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    i_test_done = 1;
                    i_test_pass = pattern[tap];
                end else begin
                    stray_ok = 0;
                end
            end else if (stray_en && stray_ok && $urandom_range(0, 15) == 0) begin
                i_test_done = 1;
                i_test_pass = 1'($urandom_range(0, 1));
            end
        end
    end

    // Strobe monitor: it timestamps pulses and checks their shape.
    initial begin
        forever begin
            @(negedge clk);
            if (o_cfg_en || o_cfg_rst) checkOutput("en_rst_exclusive", o_cfg_en && o_cfg_rst, 0);
            if (o_cfg_en || o_cfg_inc) checkOutput("inc_follows_en", o_cfg_inc, o_cfg_en);
            if (o_cfg_en) begin
                checkOutput("en_width", prev_en, 0);
                en_q.push_back(cyc);
            end
            if (o_cfg_rst) begin
                checkOutput("rst_width", prev_rst, 0);
                rst_q.push_back(cyc);
            end
            if (o_test_req) req_q.push_back(cyc);
            prev_en  = o_cfg_en;
            prev_rst = o_cfg_rst;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_pattern();
        for (int t = 0; t < NTAPS; t++) begin
            pattern[t] = 0;
            silent[t]  = 0;
        end
    endtask

    task automatic set_window(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pattern[t] = 1;
    endtask

    task automatic random_pattern(input int pass_pct, input int silent_pct);
        for (int t = 0; t < NTAPS; t++) begin
            pattern[t] = ($urandom_range(0, 99) < pass_pct);
            silent[t]  = ($urandom_range(0, 99) < silent_pct);
        end
    endtask

    // Brute force: the longest run of effective passes, earliest start on ties
    task automatic ref_model(output int blen, output int bstart);
        blen   = 0;
        bstart = 0;
        for (int s = 0; s < NTAPS; s++) begin
            int l = 0;
            while (s + l < NTAPS && pattern[s + l] && !silent[s + l]) l++;
            if (l > blen) begin
                blen   = l;
                bstart = s;
            end
        end
    endtask

    task automatic start_cal(output int n0);
        @(negedge clk);
        rst_q.delete();
        en_q.delete();
        req_q.delete();
        req_cnt  = 0;
        stray_ok = 0;
        i_start  = 1;
        n0       = cyc;
        @(negedge clk);
        i_start = 0;
        checkOutput("busy_after_start", o_busy, 1);
        checkOutput("done_cleared_on_start", o_done, 0);
        checkOutput("fail_cleared_on_start", o_fail, 0);
    endtask

    task automatic wait_req(input int n, input string tag);
        bit ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (req_cnt >= n) begin
                ok = 1;
                break;
            end
        end
        checkOutput(tag, ok, 1);
    endtask

    task automatic applyStimulus(input string name, input bit poke);
        int  blen, bstart, tgt, n0, rr, bad, done_cyc;
        bit  ok = 0;
        ref_model(blen, bstart);
        tgt = (blen == 0) ? 0 : bstart + (blen - 1) / 2;
        start_cal(n0);
        done_cyc = -1;
        for (int i = 0; i < 40000; i++) begin
            if (o_done) begin
                ok       = 1;
                done_cyc = cyc;
                break;
            end
            i_start = poke && ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        i_start = 0;
        checkOutput({name, ":done_in_budget"}, ok, 1);
        if (ok) begin
            checkOutput({name, ":busy_at_done"}, o_busy, 0);
            checkOutput({name, ":fail"}, o_fail, (blen == 0));
            checkOutput({name, ":tap"}, o_tap, tgt);
            checkOutput({name, ":best_len"}, o_best_len, blen);
            checkOutput({name, ":req_count"}, req_q.size(), NTAPS);
            checkOutput({name, ":start_rst_time"}, (rst_q.size() > 0) ? rst_q[0] : -1, n0 + 1);
            checkOutput({name, ":first_req_time"}, (req_q.size() > 0) ? req_q[0] : -1,
                        n0 + 2 + SETTLE);
            checkOutput({name, ":rst_count"}, rst_q.size(), 2);
            checkOutput({name, ":en_count"}, en_q.size(), MAX_TAP + tgt);
            if (rst_q.size() == 2 && en_q.size() == MAX_TAP + tgt && req_q.size() == NTAPS) begin
                bad = 0;
                for (int i = 0; i < MAX_TAP; i++)
                    if (en_q[i] + 1 + SETTLE != req_q[i + 1]) bad++;
                checkOutput({name, ":step_gap_errors"}, bad, 0);
                rr = rst_q[1];
                checkOutput({name, ":rewind_after_sweep"}, rr > req_q[NTAPS - 1], 1);
                bad = 0;
                for (int k = 0; k < tgt; k++)
                    if (en_q[MAX_TAP + k] != rr + (k + 1) * (SETTLE + 1)) bad++;
                checkOutput({name, ":rewind_spacing_errors"}, bad, 0);
                checkOutput({name, ":done_time"}, done_cyc, rr + (tgt + 1) * (SETTLE + 1));
            end
            @(negedge clk);
            checkOutput({name, ":done_holds"}, o_done, 1);
            checkOutput({name, ":idle_not_busy"}, o_busy, 0);
        end
    endtask

    initial begin
        int n0, nrst;
        rst      = 1;
        i_locked = 1;
        i_start  = 0;
        clear_pattern();
        repeat (3) @(negedge clk);
        checkOutput("outputs_in_reset", all_outs, 0);
        rst = 0;
        @(negedge clk);
        checkOutput("outputs_after_reset", all_outs, 0);

        $display("[TB] single window 40..59");
        clear_pattern();
        set_window(40, 59);
        applyStimulus("win40", 0);

        $display("[TB] equal windows, earliest wins");
        clear_pattern();
        set_window(10, 14);
        set_window(100, 104);
        applyStimulus("tie", 0);

        $display("[TB] every tap passes");
        clear_pattern();
        set_window(0, MAX_TAP);
        applyStimulus("all_pass", 0);

        $display("[TB] tester never answers");
        clear_pattern();
        for (int t = 0; t < NTAPS; t++) silent[t] = 1;
        applyStimulus("silent", 0);

        $display("[TB] window ending on the last tap");
        clear_pattern();
        set_window(0, 10);
        set_window(200, MAX_TAP);
        applyStimulus("edge", 0);

        $display("[TB] random patterns with stray strobes and busy starts");
        stray_en = 1;
        for (int r = 0; r < 3; r++) begin
            random_pattern($urandom_range(70, 95), 3);
            applyStimulus($sformatf("rand%0d", r), 1);
        end
        stray_en = 0;

        $display("[TB] lock loss during tap 30");
        clear_pattern();
        set_window(0, MAX_TAP);
        start_cal(n0);
        wait_req(31, "lock:reach_tap30");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        nrst     = rst_q.size();
        i_locked = 0;
        @(negedge clk);
        checkOutput("lock:abort_rst_pulse", o_cfg_rst, 1);
        checkOutput("lock:abort_not_done_yet", o_done, 0);
        @(negedge clk);
        checkOutput("lock:done", o_done, 1);
        checkOutput("lock:fail", o_fail, 1);
        checkOutput("lock:tap", o_tap, 0);
        checkOutput("lock:best_len", o_best_len, 0);
        checkOutput("lock:not_busy", o_busy, 0);
        checkOutput("lock:rst_pulse_count", rst_q.size() - nrst, 1);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        @(negedge clk);
        checkOutput("lock:start_ignored_unlocked", o_busy, 0);
        checkOutput("lock:done_kept_unlocked", o_done, 1);
        i_locked = 1;
        random_pattern(85, 0);
        applyStimulus("relock", 0);

        $display("[TB] reset mid-sweep");
        random_pattern(80, 0);
        start_cal(n0);
        wait_req(20, "rst:reach_tap20");
        checkOutput("rst:busy_before", o_busy, 1);
        rst = 1;
        @(negedge clk);
        checkOutput("rst:outputs_cleared", all_outs, 0);
        rst = 0;
        @(negedge clk);
        checkOutput("rst:outputs_idle", all_outs, 0);
        random_pattern(90, 2);
        applyStimulus("after_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
